// File: rtl/sng_pkg.sv
// Shared song-path types: word field widths, decoded length, timer states.
// Used by the sequencer, the duration timer and the tone stage.
package sng_pkg;

  localparam int LEN_W     = 4;
  localparam int REM_W     = 5;
  localparam int MAX_UNITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    COUNT
  } sng_state_e;

  // A zero duration code stands for the longest note.
  function automatic logic [REM_W-1:0] decode_len(
    input logic [LEN_W-1:0] len
  );
    logic [REM_W-1:0] r;
    r = (len == '0) ? REM_W'(MAX_UNITS) : REM_W'(len);
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to one tick strobe per duration unit.
// Freezes while run is low; clear restarts the unit from zero.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 3125000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + PW'(1);
    end
  end

endmodule

// File: rtl/note_duration_timer.sv
// Counts out each note's duration in tempo ticks and strobes note_change,
// waiting out the song ROM latency before sampling the next length.
module note_duration_timer
  import sng_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 3125000,
  parameter int unsigned LOAD_DELAY = 2,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [LEN_W-1:0] length,
  output logic             note_change,
  output logic             articulate,
  output logic             tick,
  output logic [REM_W-1:0] remaining,
  output logic             busy
);

  if (LOAD_DELAY < 1) begin : g_bad_delay
    $error("note_duration_timer: LOAD_DELAY must be >= 1");
  end
  if (TICK_DIV < LOAD_DELAY + 2) begin : g_bad_div
    $error("note_duration_timer: TICK_DIV must be >= LOAD_DELAY+2");
  end

  localparam int unsigned DW =
    (LOAD_DELAY > 1) ? $clog2(LOAD_DELAY) : 1;
  localparam logic [DW-1:0] DLY_INIT = DW'(LOAD_DELAY - 1);

  sng_state_e       state_q, state_d;
  logic [DW-1:0]    dly_q, dly_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic             art_q, art_d;
  logic             run;
  logic             clear;
  logic             last_unit;

  assign run       = en && (state_q != IDLE);
  assign clear     = en && (state_q == IDLE);
  assign last_unit = (rem_q == REM_W'(1));

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clear(clear),
    .tick (tick)
  );

  assign note_change = tick && (state_q == COUNT) && last_unit;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    rem_d   = rem_q;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          state_d = FETCH;
          dly_d   = DLY_INIT;
        end
        FETCH: begin
          if (dly_q == '0) state_d = LOAD;
          else dly_d = dly_q - DW'(1);
        end
        LOAD: begin
          rem_d   = decode_len(length);
          state_d = COUNT;
        end
        COUNT: begin
          if (tick) begin
            if (last_unit) begin
              state_d = FETCH;
              dly_d   = DLY_INIT;
            end else begin
              rem_d = rem_q - REM_W'(1);
            end
          end
        end
      endcase
    end
  end

  // Registered from next-state so the mute gap lines up with the count.
  always_comb begin
    art_d = (state_d == COUNT) && (GAP_TICKS != 0) &&
            (32'(rem_d) <= GAP_TICKS);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      dly_q   <= '0;
      rem_q   <= '0;
      art_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      rem_q   <= rem_d;
      art_q   <= art_d;
    end
  end

  assign remaining  = rem_q;
  assign articulate = art_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_note_duration_timer.sv
// Directed bench for note_duration_timer (TICK_DIV=8, LOAD_DELAY=2).
// A second instance with GAP_TICKS=0 shares all inputs.
module tb_note_duration_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] length;

  logic       nc, art, tck, busy;
  logic [4:0] rem;
  logic       nc0, art0, tck0, busy0;
  logic [4:0] rem0;

  int cyc = 0;
  int checks = 0;
  int fails = 0;
  int art0_hi = 0;
  int diff0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  note_duration_timer #(
    .TICK_DIV(8), .LOAD_DELAY(2), .GAP_TICKS(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .length(length),
    .note_change(nc), .articulate(art), .tick(tck),
    .remaining(rem), .busy(busy)
  );

  note_duration_timer #(
    .TICK_DIV(8), .LOAD_DELAY(2), .GAP_TICKS(0)
  ) dut0 (
    .clk(clk), .rst(rst), .en(en), .length(length),
    .note_change(nc0), .articulate(art0), .tick(tck0),
    .remaining(rem0), .busy(busy0)
  );

  always @(negedge clk) begin
    if (art0 === 1'b1) art0_hi++;
    if (rst === 1'b1 && (nc0 !== nc || tck0 !== tck ||
        rem0 !== rem || busy0 !== busy)) diff0++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_nc(output int at);
    at = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (nc === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) chk("nc_timeout", 0, 1);
  endtask

  initial begin
    int f, s, t, bad, hi;
    rst = 1'b0; en = 1'b1; length = 4'd3;
    step(3);
    chk("rst_nc", nc, 0);
    chk("rst_art", art, 0);
    chk("rst_tick", tck, 0);
    chk("rst_rem", rem, 0);
    chk("rst_busy", busy, 0);

    // Scenario 1: length 3 from reset release
    rst = 1'b1;
    step(1); f = cyc;
    chk("fetch_busy", busy, 1);
    step(3); chk("rem_3", rem, 3);
    step(5); chk("rem_2", rem, 2);
    step(8); chk("rem_1", rem, 1);
    chk("art_last", art, 1);
    wait_nc(s); chk("first_nc", s - f, 23);
    wait_nc(t); chk("nc_24", t - s, 24);

    // Scenario 2: code 0 = 16 units
    length = 4'd0;
    step(4); chk("rem_16", rem, 16);
    wait_nc(s); chk("nc_128", s - t, 128);

    // Scenario 3: sequencer-timed length updates
    length = 4'd2;
    wait_nc(t); chk("nc_16", t - s, 16);
    step(2); length = 4'd5;
    wait_nc(s); chk("nc_40_late", s - t, 40);
    length = 4'd2;
    step(1); length = 4'd5;
    step(8); length = 4'd7;
    wait_nc(t); chk("nc_40_early", t - s, 40);

    // Scenario 4: 13-cycle pause in last unit
    length = 4'd4;
    step(26);
    chk("pre_pause_rem", rem, 1);
    chk("pre_pause_art", art, 1);
    en = 1'b0;
    bad = 0;
    for (int i = 0; i < 13; i++) begin
      if (tck !== 1'b0 || nc !== 1'b0 || rem !== 5'd1 ||
          art !== 1'b1) bad++;
      step(1);
    end
    chk("pause_hold", bad, 0);
    en = 1'b1;
    wait_nc(s); chk("nc_45", s - t, 45);

    // Scenario 5: articulate window
    hi = 0; t = -1;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if (art === 1'b1) hi++;
      if (nc === 1'b1) begin
        t = cyc;
        break;
      end
    end
    chk("art_cycles", hi, 8);
    chk("nc_32", t - s, 32);

    // Pause landing on a tick cycle
    step(8); chk("tick_pre", tck, 1);
    en = 1'b0; #1;
    chk("tick_gated", tck, 0);
    chk("nc_gated", nc, 0);
    step(2); en = 1'b1; #1;
    chk("tick_resume", tck, 1);
    wait_nc(s); chk("nc_34", s - t, 34);

    // Scenario 6: reset mid-note, idle hold, restart
    step(10); rst = 1'b0;
    step(1);
    chk("rst2_nc", nc, 0);
    chk("rst2_art", art, 0);
    chk("rst2_tick", tck, 0);
    chk("rst2_rem", rem, 0);
    chk("rst2_busy", busy, 0);
    en = 1'b0; rst = 1'b1;
    step(3); chk("idle_hold", busy, 0);
    length = 4'd3; en = 1'b1;
    step(1); f = cyc;
    chk("fetch2_busy", busy, 1);
    step(3); chk("rem2_3", rem, 3);
    wait_nc(s); chk("first_nc2", s - f, 23);

    chk("gap0_art", art0_hi, 0);
    chk("gap0_match", diff0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
